// File: rtl/commit_checker.sv
// Commit-stream checker: lane packing, order and halt checks, segment and total
// performance counters, and a commit watchdog. All outputs come straight from flops.
module commit_checker #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned WDOG_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      valid,
  input  logic [CHANNELS-1:0][63:0] order,
  input  logic [CHANNELS-1:0][31:0] inst,
  output logic                     halt_o,
  output logic [1:0]               seg_state_o,
  output logic [CNT_W-1:0]         seg_insts_o,
  output logic [CNT_W-1:0]         seg_cycles_o,
  output logic [CNT_W-1:0]         total_insts_o,
  output logic [CNT_W-1:0]         total_cycles_o,
  output logic [3:0]               err_code_o,
  output logic                     err_o
);

  localparam int unsigned LANE_W = $clog2(CHANNELS + 1);
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  localparam logic [31:0] HALT_A    = 32'h0000_0063;
  localparam logic [31:0] HALT_B    = 32'h0000_006f;
  localparam logic [31:0] HALT_C    = 32'hF000_2013;
  localparam logic [31:0] SEG_START = 32'h0010_2013;
  localparam logic [31:0] SEG_STOP  = 32'h0020_2013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seg_state_t;

  seg_state_t        state, state_n;
  logic              halt_n;
  logic [CNT_W-1:0]  seg_insts_n, seg_cycles_n, total_insts_n, total_cycles_n;
  logic [3:0]        err_n;
  logic [63:0]       expect_q, expect_n;
  logic [WDOG_W-1:0] wdog_q, wdog_n;
  logic [LANE_W-1:0] accepted;
  logic              cut;
  logic              started;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [LANE_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic is_halt(input logic [31:0] w);
    return (w == HALT_A) || (w == HALT_B) || (w == HALT_C);
  endfunction

  // Next-state: lanes walked in index order so markers and halt cut apply in lane order.
  always_comb begin
    state_n      = state;
    halt_n       = halt_o;
    seg_insts_n  = seg_insts_o;
    seg_cycles_n = seg_cycles_o;
    expect_n     = expect_q;
    wdog_n       = wdog_q;
    err_n        = err_code_o;
    accepted     = '0;
    cut          = 1'b0;
    started      = 1'b0;

    for (int k = 1; k < CHANNELS; k++) begin
      if (valid[k] && !valid[k-1]) err_n[0] = 1'b1;
    end

    for (int k = 0; k < CHANNELS; k++) begin
      if (valid[k]) begin
        if (halt_o) begin
          err_n[2] = 1'b1;
        end else if (!cut) begin
          if (order[k] != expect_q + 64'(accepted)) err_n[1] = 1'b1;
          accepted = accepted + LANE_W'(1);
          if (is_halt(inst[k])) begin
            halt_n = 1'b1;
            cut    = 1'b1;
          end
          if (inst[k] == SEG_START) begin
            state_n     = RUN;
            seg_insts_n = '0;
            started     = 1'b1;
          end else if (state_n == RUN) begin
            seg_insts_n = sat_add(seg_insts_n, LANE_W'(1));
            if (inst[k] == SEG_STOP) state_n = DONE;
          end
        end
      end
    end

    // A cycle that began in RUN is counted even if it ends with a stop.
    if (started) seg_cycles_n = '0;
    else if (state == RUN) seg_cycles_n = sat_add(seg_cycles_o, LANE_W'(1));

    total_cycles_n = sat_add(total_cycles_o, LANE_W'(1));
    total_insts_n  = sat_add(total_insts_o, accepted);
    expect_n       = expect_q + 64'(accepted);

    if (!halt_o) begin
      if (accepted != '0) wdog_n = '0;
      else if (wdog_q != WDOG_W'(WDOG_CYCLES)) wdog_n = wdog_q + WDOG_W'(1);
      if (wdog_n == WDOG_W'(WDOG_CYCLES)) err_n[3] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      halt_o         <= 1'b0;
      seg_insts_o    <= '0;
      seg_cycles_o   <= '0;
      total_insts_o  <= '0;
      total_cycles_o <= '0;
      err_code_o     <= '0;
      err_o          <= 1'b0;
      expect_q       <= '0;
      wdog_q         <= '0;
    end else begin
      state          <= state_n;
      halt_o         <= halt_n;
      seg_insts_o    <= seg_insts_n;
      seg_cycles_o   <= seg_cycles_n;
      total_insts_o  <= total_insts_n;
      total_cycles_o <= total_cycles_n;
      err_code_o     <= err_n;
      err_o          <= |err_n;
      expect_q       <= expect_n;
      wdog_q         <= wdog_n;
    end
  end

  assign seg_state_o = state;

endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker (2 lanes, 8-bit counters, 16-cycle watchdog)
// with hand-computed expected values.
module tb_commit_checker;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JAL   = 32'h0000_006f;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] START = 32'h0010_2013;
  localparam logic [31:0] STOP  = 32'h0020_2013;

  logic             clk;
  logic             rst;
  logic [1:0]       valid;
  logic [1:0][63:0] order;
  logic [1:0][31:0] inst;
  logic             halt_o;
  logic [1:0]       seg_state_o;
  logic [7:0]       seg_insts_o, seg_cycles_o, total_insts_o, total_cycles_o;
  logic [3:0]       err_code_o;
  logic             err_o;

  int tests  = 0;
  int failed = 0;

  commit_checker #(
    .CHANNELS   (2),
    .CNT_W      (8),
    .WDOG_CYCLES(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid         (valid),
    .order         (order),
    .inst          (inst),
    .halt_o        (halt_o),
    .seg_state_o   (seg_state_o),
    .seg_insts_o   (seg_insts_o),
    .seg_cycles_o  (seg_cycles_o),
    .total_insts_o (total_insts_o),
    .total_cycles_o(total_cycles_o),
    .err_code_o    (err_code_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                     input logic [31:0] i0, input logic [31:0] i1);
    valid    = v;
    order[0] = o0;
    order[1] = o1;
    inst[0]  = i0;
    inst[1]  = i1;
    @(posedge clk);
    #1;
    valid = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 64'd0, 64'd0, NOP, NOP);
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    valid = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b0;
    valid = 2'b00;
    order = '0;
    inst  = '0;
    @(posedge clk);
    #1;
    check("reset_halt",   64'(halt_o),         64'd0);
    check("reset_state",  64'(seg_state_o),    64'd0);
    check("reset_tcyc",   64'(total_cycles_o), 64'd0);
    check("reset_err",    64'(err_code_o),     64'd0);
    rst = 1'b1;

    // Dual-lane streaming, orders 0..19
    for (int i = 0; i < 10; i++) cyc(2'b11, 64'(2*i), 64'(2*i+1), NOP, NOP);
    check("stream_tinsts", 64'(total_insts_o),  64'd20);
    check("stream_tcyc",   64'(total_cycles_o), 64'd10);
    check("stream_err_o",  64'(err_o),          64'd0);
    check("stream_state",  64'(seg_state_o),    64'd0);

    // Packing error, then order error on top
    do_reset();
    cyc(2'b10, 64'd0, 64'd0, NOP, NOP);
    check("pack_err",     64'(err_code_o),    64'h1);
    check("pack_err_o",   64'(err_o),         64'd1);
    check("pack_tinsts",  64'(total_insts_o), 64'd1);
    cyc(2'b01, 64'd5, 64'd0, NOP, NOP);
    check("order_err",    64'(err_code_o),    64'h3);
    cyc(2'b01, 64'd2, 64'd0, NOP, NOP);
    check("order_advance", 64'(err_code_o),   64'h3);
    check("order_tinsts", 64'(total_insts_o), 64'd3);

    // Segment: start lane 0, four counted cycles, stop on lane 1
    do_reset();
    cyc(2'b11, 64'd0, 64'd1, START, NOP);
    check("seg_start_state", 64'(seg_state_o),  64'd1);
    check("seg_start_insts", 64'(seg_insts_o),  64'd1);
    check("seg_start_cyc",   64'(seg_cycles_o), 64'd0);
    cyc(2'b11, 64'd2, 64'd3, NOP, NOP);
    check("seg_mid_insts",   64'(seg_insts_o),  64'd3);
    check("seg_mid_cyc",     64'(seg_cycles_o), 64'd1);
    cyc(2'b11, 64'd4, 64'd5, NOP, NOP);
    cyc(2'b11, 64'd6, 64'd7, NOP, NOP);
    cyc(2'b11, 64'd8, 64'd9, NOP, STOP);
    check("seg_stop_insts",  64'(seg_insts_o),  64'd9);
    check("seg_stop_cyc",    64'(seg_cycles_o), 64'd4);
    check("seg_stop_state",  64'(seg_state_o),  64'd2);
    cyc(2'b11, 64'd10, 64'd11, NOP, NOP);
    check("seg_frozen_insts", 64'(seg_insts_o),  64'd9);
    check("seg_frozen_cyc",   64'(seg_cycles_o), 64'd4);
    check("seg_tinsts",       64'(total_insts_o), 64'd12);
    check("seg_err",          64'(err_code_o),   64'h0);

    // Start and stop in the same cycle
    do_reset();
    cyc(2'b11, 64'd0, 64'd1, START, STOP);
    check("seg_same_state", 64'(seg_state_o), 64'd2);
    check("seg_same_insts", 64'(seg_insts_o), 64'd1);

    // Halt on lane 0 cuts lane 1 (its bad order is ignored); later commit errors
    do_reset();
    cyc(2'b11, 64'd0, 64'd99, JAL, NOP);
    check("halt_flag",   64'(halt_o),        64'd1);
    check("halt_tinsts", 64'(total_insts_o), 64'd1);
    check("halt_err",    64'(err_code_o),    64'h0);
    cyc(2'b01, 64'd1, 64'd0, NOP, NOP);
    check("post_halt_err",    64'(err_code_o),    64'h4);
    check("post_halt_tinsts", 64'(total_insts_o), 64'd1);
    check("post_halt_sticky", 64'(halt_o),        64'd1);

    // Watchdog fires on the 16th commit-free cycle
    do_reset();
    idle(15);
    check("wdog_15", 64'(err_code_o), 64'h0);
    idle(1);
    check("wdog_16", 64'(err_code_o), 64'h8);
    check("wdog_err_o", 64'(err_o), 64'd1);

    // Watchdog frozen after halt
    do_reset();
    cyc(2'b01, 64'd0, 64'd0, BEQ, NOP);
    idle(20);
    check("wdog_halted", 64'(err_code_o), 64'h0);
    check("wdog_halt_flag", 64'(halt_o), 64'd1);

    // Reset mid-segment abandons everything, inputs ignored
    do_reset();
    cyc(2'b11, 64'd0, 64'd1, START, NOP);
    cyc(2'b11, 64'd2, 64'd3, NOP, NOP);
    cyc(2'b11, 64'd4, 64'd5, NOP, NOP);
    cyc(2'b11, 64'd6, 64'd7, NOP, NOP);
    check("rst_pre_insts", 64'(seg_insts_o), 64'd7);
    rst      = 1'b0;
    valid    = 2'b11;
    order[0] = 64'd8;
    order[1] = 64'd9;
    inst[0]  = JAL;
    inst[1]  = NOP;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    valid = 2'b00;
    check("rst_seg_insts", 64'(seg_insts_o),    64'd0);
    check("rst_seg_cyc",   64'(seg_cycles_o),   64'd0);
    check("rst_state",     64'(seg_state_o),    64'd0);
    check("rst_tinsts",    64'(total_insts_o),  64'd0);
    check("rst_tcyc",      64'(total_cycles_o), 64'd0);
    check("rst_halt",      64'(halt_o),         64'd0);
    check("rst_err_o",     64'(err_o),          64'd0);
    cyc(2'b01, 64'd0, 64'd0, NOP, NOP);
    check("rst_order_restart", 64'(err_code_o),     64'h0);
    check("rst_first_cycle",   64'(total_cycles_o), 64'd1);

    // Saturation of 8-bit total cycle counter
    do_reset();
    idle(300);
    check("sat_tcyc", 64'(total_cycles_o), 64'd255);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
